// File: rtl/cmp_mmio_pkg.sv
// Shared decode constants, FSM state and response-tag types for the CMP core
// memory-mapped access router.
package cmp_mmio_pkg;

   // NIC window: address bits [16:17] == 2'b11 (bit 0 is the MSB)
   localparam logic [1:0] NIC_WINDOW = 2'b11;
   localparam int         NIC_WIN_LO = 16;
   localparam int         CH_BASE    = 18;
   localparam int         TAG_CH_W   = 4;

   typedef enum logic [1:0] {
      SRC_DMEM,
      SRC_NIC,
      SRC_ZERO
   } rsp_src_e;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } fsm_state_e;

   typedef struct packed {
      logic                valid;
      rsp_src_e            src;
      logic [TAG_CH_W-1:0] ch;
   } rsp_tag_t;

endpackage

// File: rtl/cmp_rsp_tag_pipe.sv
// RD_LAT-deep shift register of load-response tags; the last stage lines up
// with the cycle the addressed memory presents its read data.
module cmp_rsp_tag_pipe
   import cmp_mmio_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  rsp_tag_t tag_in,
   output rsp_tag_t tag_out
);

   rsp_tag_t stage_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/cmp_mmio_router.sv
// Routes core loads/stores to data memory or one of NCH NIC channels, stalls
// on a busy channel with a bounded wait, and steers load data by issue tag.
module cmp_mmio_router
   import cmp_mmio_pkg::*;
#(
   parameter int DW       = 64,
   parameter int NCH      = 4,
   parameter int CH_W     = 2,
   parameter int RD_LAT   = 1,
   parameter int WAIT_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:31]       cpu_addr,
   input  logic [0:DW-1]     cpu_din,
   input  logic              cpu_memEn,
   input  logic              cpu_wrEn,
   output logic [0:DW-1]     cpu_dout,
   output logic              cpu_stall,
   output logic              bus_err,
   output logic [0:31]       dmem_addr,
   output logic [0:DW-1]     dmem_din,
   output logic              dmem_en,
   output logic              dmem_wrEn,
   input  logic [0:DW-1]     dmem_dout,
   output logic [0:1]        nic_addr,
   output logic [0:DW-1]     nic_din,
   output logic [0:NCH-1]    nic_en,
   output logic [0:NCH-1]    nic_wrEn,
   input  logic [0:NCH-1]    nic_rdy,
   input  logic [0:NCH*DW-1] nic_dout,
   output fsm_state_e        dbg_state
);

   localparam int                 WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(WAIT_MAX);

   // Handshake: the core holds cpu_addr/cpu_din/cpu_memEn/cpu_wrEn stable while
   // cpu_stall is high; an access completes in the first cycle with memEn=1 and
   // cpu_stall=0, and its load data appears on cpu_dout RD_LAT cycles later.

   fsm_state_e          state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                bus_err_q;
   logic                nic_win, ch_mapped, ch_rdy;
   logic                nic_hit, dmem_hit, unmapped;
   logic                stall, issue, abort;
   logic [CH_W-1:0]     ch;
   rsp_tag_t            tag_in, tag_out;

   assign nic_win  = (cpu_addr[NIC_WIN_LO +: 2] == NIC_WINDOW);
   assign ch       = cpu_addr[CH_BASE +: CH_W];
   assign nic_addr = cpu_addr[30:31];

   always_comb begin
      ch_mapped = 1'b0;
      ch_rdy    = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (ch == c[CH_W-1:0]) begin
            ch_mapped = 1'b1;
            ch_rdy    = nic_rdy[c];
         end
      end
   end

   assign nic_hit  = cpu_memEn & nic_win & ch_mapped;
   assign unmapped = cpu_memEn & nic_win & ~ch_mapped;
   assign dmem_hit = cpu_memEn & ~nic_win;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= abort | unmapped;
      end
   end

   // Leaving WAIT for any reason other than a further stall clears the count;
   // a request that moves off the NIC window is simply abandoned.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      stall      = 1'b0;
      issue      = 1'b0;
      abort      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (nic_hit) begin
               if (ch_rdy) begin
                  issue = 1'b1;
               end else begin
                  stall      = 1'b1;
                  wait_cnt_d = WAIT_W'(1);
                  state_d    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            if (nic_hit) begin
               if (ch_rdy) begin
                  issue = 1'b1;
               end else if (wait_cnt_q < WAIT_LIM) begin
                  stall      = 1'b1;
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                  state_d    = ST_WAIT;
               end else begin
                  abort = 1'b1;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   assign dmem_addr = cpu_addr;
   assign dmem_din  = cpu_din;
   assign nic_din   = cpu_din;
   assign dmem_en   = ~reset & dmem_hit;
   assign dmem_wrEn = ~reset & dmem_hit & cpu_wrEn;
   assign cpu_stall = ~reset & stall;
   assign bus_err   = bus_err_q;
   assign dbg_state = state_q;

   always_comb begin
      nic_en   = '0;
      nic_wrEn = '0;
      for (int c = 0; c < NCH; c++) begin
         nic_en[c]   = ~reset & issue & (ch == c[CH_W-1:0]);
         nic_wrEn[c] = ~reset & issue & cpu_wrEn & (ch == c[CH_W-1:0]);
      end
   end

   // Aborted and unmapped loads still take a tag so their zero lands in order.
   always_comb begin
      tag_in       = '0;
      tag_in.valid = cpu_memEn & ~cpu_wrEn & ~stall;
      tag_in.ch    = TAG_CH_W'(ch);
      if (dmem_hit)   tag_in.src = SRC_DMEM;
      else if (issue) tag_in.src = SRC_NIC;
      else            tag_in.src = SRC_ZERO;
   end

   cmp_rsp_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   always_comb begin
      cpu_dout = '0;
      if (tag_out.valid) begin
         case (tag_out.src)
            SRC_DMEM: cpu_dout = dmem_dout;
            SRC_NIC: begin
               for (int c = 0; c < NCH; c++) begin
                  if (tag_out.ch == TAG_CH_W'(c)) cpu_dout = nic_dout[c*DW +: DW];
               end
            end
            default: cpu_dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_mmio_router.sv
// Directed bench for cmp_mmio_router: 3 channels (one unmapped slot), RD_LAT=2,
// scoreboard queues for load data and bus_err checked by a free-running monitor.
module tb_cmp_mmio_router;
   import cmp_mmio_pkg::*;

   localparam int DW       = 64;
   localparam int NCH      = 3;
   localparam int CH_W     = 2;
   localparam int RD_LAT   = 2;
   localparam int WAIT_MAX = 16;

   localparam int S_DMEM = 0;
   localparam int S_NIC  = 1;
   localparam int S_ZERO = 2;
   localparam int S_NONE = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [0:31]       cpu_addr;
   logic [0:DW-1]     cpu_din;
   logic              cpu_memEn, cpu_wrEn;
   logic [0:DW-1]     cpu_dout;
   logic              cpu_stall, bus_err;
   logic [0:31]       dmem_addr;
   logic [0:DW-1]     dmem_din;
   logic              dmem_en, dmem_wrEn;
   logic [0:DW-1]     dmem_dout;
   logic [0:1]        nic_addr;
   logic [0:DW-1]     nic_din;
   logic [0:NCH-1]    nic_en, nic_wrEn, nic_rdy;
   wire  [0:NCH*DW-1] nic_dout;
   fsm_state_e        dbg_state;

   logic [31:0]       cyc = 0;
   int                checks = 0;
   int                failures = 0;
   logic [DW-1:0]     exp_q[$];
   logic [31:0]       due_q[$];
   logic [31:0]       err_q[$];

   // ---------------- clock / reset / memory models ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Read data changes every cycle so a misaligned return is visible.
   assign dmem_dout = {32'hD000_0000, cyc};
   for (genvar c = 0; c < NCH; c++) begin : g_nic
      localparam logic [7:0] CH8 = 8'(c);
      assign nic_dout[c*DW +: DW] = {24'hA0_0000, CH8, cyc};
   end

   cmp_mmio_router #(
      .DW(DW), .NCH(NCH), .CH_W(CH_W), .RD_LAT(RD_LAT), .WAIT_MAX(WAIT_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_memEn(cpu_memEn), .cpu_wrEn(cpu_wrEn),
      .cpu_dout(cpu_dout), .cpu_stall(cpu_stall), .bus_err(bus_err),
      .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_en(dmem_en), .dmem_wrEn(dmem_wrEn),
      .dmem_dout(dmem_dout),
      .nic_addr(nic_addr), .nic_din(nic_din), .nic_en(nic_en), .nic_wrEn(nic_wrEn),
      .nic_rdy(nic_rdy), .nic_dout(nic_dout), .dbg_state(dbg_state)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int src, input int ch, input logic [31:0] c);
      logic [7:0] ch8;
      ch8 = 8'(ch);
      case (src)
         S_DMEM:  return {32'hD000_0000, c};
         S_NIC:   return {24'hA0_0000, ch8, c};
         default: return '0;
      endcase
   endfunction

   // ---------------- driver ----------------
   task automatic access(input string name, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [0:NCH-1] rdy,
                         input logic e_stall, input logic e_dmem, input logic [0:NCH-1] e_nic,
                         input int e_src, input int e_ch, input logic e_err);
      logic [63:0] din;
      logic [1:0]  off;
      @(negedge clk);
      #1;
      din       = {32'hC0DE_0000, addr};
      off       = addr[1:0];
      cpu_memEn = en;
      cpu_wrEn  = wr;
      cpu_addr  = addr;
      cpu_din   = din;
      nic_rdy   = rdy;
      #1;
      chk({name, ".stall"}, 64'(cpu_stall), 64'(e_stall));
      chk({name, ".dmem_en"}, 64'(dmem_en), 64'(e_dmem));
      chk({name, ".dmem_wrEn"}, 64'(dmem_wrEn), 64'(e_dmem & wr));
      chk({name, ".nic_en"}, 64'(nic_en), 64'(e_nic));
      chk({name, ".nic_wrEn"}, 64'(nic_wrEn), wr ? 64'(e_nic) : 64'd0);
      if (e_dmem) begin
         chk({name, ".dmem_addr"}, 64'(dmem_addr), 64'(addr));
         chk({name, ".dmem_din"}, dmem_din, din);
      end
      if (|e_nic) begin
         chk({name, ".nic_addr"}, 64'(nic_addr), 64'(off));
         chk({name, ".nic_din"}, nic_din, din);
      end
      if (en && !wr && !e_stall && e_src != S_NONE) begin
         exp_q.push_back(exp_data(e_src, e_ch, cyc + RD_LAT));
         due_q.push_back(cyc + RD_LAT);
      end
      if (e_err) err_q.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         access("idle", 1'b0, 1'b0, 32'h0, '1, 1'b0, 1'b0, '0, S_NONE, 0, 1'b0);
   endtask

   task automatic stuck(input string name, input logic [31:0] addr, input logic [0:NCH-1] rdy);
      for (int i = 0; i < WAIT_MAX; i++)
         access({name, ".wait"}, 1'b1, 1'b0, addr, rdy, 1'b1, 1'b0, '0, S_NONE, 0, 1'b0);
      access({name, ".abort"}, 1'b1, 1'b0, addr, rdy, 1'b0, 1'b0, '0, S_ZERO, 0, 1'b1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic e_err;
      forever begin
         @(negedge clk);
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            chk("load_data", cpu_dout, exp_q.pop_front());
         end else begin
            chk("idle_dout", cpu_dout, 64'd0);
         end
         e_err = (err_q.size() > 0 && err_q[0] == cyc);
         if (e_err) void'(err_q.pop_front());
         chk("bus_err", 64'(bus_err), 64'(e_err));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      cpu_memEn = 1'b1;
      cpu_wrEn  = 1'b0;
      cpu_addr  = 32'h0000_0010;
      cpu_din   = '0;
      nic_rdy   = '1;

      // Request held during reset must not reach any target.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         chk("rst.dmem_en", 64'(dmem_en), 64'd0);
         chk("rst.nic_en", 64'(nic_en), 64'd0);
         chk("rst.stall", 64'(cpu_stall), 64'd0);
      end
      @(negedge clk);
      #1;
      reset     = 1'b0;
      cpu_memEn = 1'b0;

      access("ld_dmem", 1, 0, 32'h0000_0010, 3'b111, 0, 1, 3'b000, S_DMEM, 0, 0);
      access("st_nic0", 1, 1, 32'h0000_C003, 3'b111, 0, 0, 3'b100, S_NONE, 0, 0);
      idle(3);

      for (int i = 0; i < 3; i++)
         access("ld_ch2.wait", 1, 0, 32'h0000_E000, 3'b110, 1, 0, 3'b000, S_NONE, 0, 0);
      access("ld_ch2.issue", 1, 0, 32'h0000_E000, 3'b111, 0, 0, 3'b001, S_NIC, 2, 0);
      idle(3);

      stuck("ld_ch1", 32'h0000_D000, 3'b101);
      idle(3);

      access("ld_unmapped", 1, 0, 32'h0000_F000, 3'b111, 0, 0, 3'b000, S_ZERO, 0, 1);
      access("st_unmapped", 1, 1, 32'h0000_F004, 3'b111, 0, 0, 3'b000, S_NONE, 0, 1);
      idle(3);

      // Back-to-back loads alternating targets, plus a dmem store.
      access("alt.d0", 1, 0, 32'h0000_0020, 3'b111, 0, 1, 3'b000, S_DMEM, 0, 0);
      access("alt.n0", 1, 0, 32'h0000_C000, 3'b111, 0, 0, 3'b100, S_NIC, 0, 0);
      access("alt.d1", 1, 0, 32'h0000_0030, 3'b111, 0, 1, 3'b000, S_DMEM, 0, 0);
      access("alt.n2", 1, 0, 32'h0000_E001, 3'b111, 0, 0, 3'b001, S_NIC, 2, 0);
      access("alt.n1", 1, 0, 32'h0000_D002, 3'b111, 0, 0, 3'b010, S_NIC, 1, 0);
      access("st_dmem", 1, 1, 32'h0000_0040, 3'b111, 0, 1, 3'b000, S_NONE, 0, 0);
      idle(3);

      // Request dropped while waiting: no error, no enable.
      access("drop.wait", 1, 0, 32'h0000_C000, 3'b011, 1, 0, 3'b000, S_NONE, 0, 0);
      access("drop.release", 0, 0, 32'h0000_C000, 3'b011, 0, 0, 3'b000, S_NONE, 0, 0);
      idle(2);

      // Reset while waiting abandons the access silently.
      access("rstw.wait", 1, 0, 32'h0000_E000, 3'b110, 1, 0, 3'b000, S_NONE, 0, 0);
      access("rstw.wait", 1, 0, 32'h0000_E000, 3'b110, 1, 0, 3'b000, S_NONE, 0, 0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rstw.stall", 64'(cpu_stall), 64'd0);
      chk("rstw.nic_en", 64'(nic_en), 64'd0);
      @(negedge clk);
      #1;
      reset     = 1'b0;
      cpu_memEn = 1'b0;
      idle(2);

      // Wait counter must restart from scratch after the reset.
      stuck("ld_ch2_post_rst", 32'h0000_E000, 3'b110);
      access("post.d", 1, 0, 32'h0000_0050, 3'b111, 0, 1, 3'b000, S_DMEM, 0, 0);
      idle(RD_LAT + 2);

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("err_q_drained", 64'(err_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
